// File: rtl/alu_operand_sequencer_if.sv
// Bus between the lab-board input logic, the ALU front-end sequencer and the ALU.
// Optional flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_operand_sequencer_if #(
   parameter int N_BITS  = 8,
   parameter int OP_BITS = 2
);
   logic [N_BITS-1:0]  dato_in;
   logic               cargar;
   logic               borrar;
   logic [N_BITS-1:0]  entrada_a;
   logic [N_BITS-1:0]  entrada_b;
   logic [OP_BITS-1:0] op_sel;
   logic [N_BITS-1:0]  resultado_alu;
   logic [N_BITS-1:0]  resultado;
   logic               valido;
   logic [2:0]         estado;
`ifdef ALU_FLAGS_EN
   logic               flag_cero;
   logic               flag_neg;
`endif

   // Board/ALU side: supplies data, strobes and the ALU result.
   modport master (
      output dato_in, cargar, borrar, resultado_alu,
      input  entrada_a, entrada_b, op_sel, resultado, valido, estado
`ifdef ALU_FLAGS_EN
      , input flag_cero, flag_neg
`endif
   );

   // Sequencer side.
   modport slave (
      input  dato_in, cargar, borrar, resultado_alu,
      output entrada_a, entrada_b, op_sel, resultado, valido, estado
`ifdef ALU_FLAGS_EN
      , output flag_cero, flag_neg
`endif
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and opcode from a shared bus, then captures the ALU result.
// Define ALU_FLAGS_EN to add registered zero/negative flags captured with the result.
module alu_operand_sequencer #(
   parameter int N_BITS  = 8,
   parameter int OP_BITS = 2
) (
   input logic                   clk,
   input logic                   reset_n,
   alu_operand_sequencer_if.slave bus
);
   localparam logic [2:0] ESPERA_A  = 3'd0;
   localparam logic [2:0] ESPERA_B  = 3'd1;
   localparam logic [2:0] ESPERA_OP = 3'd2;
   localparam logic [2:0] CALCULA   = 3'd3;
   localparam logic [2:0] MUESTRA   = 3'd4;

   logic [2:0]         estado_r;
   logic [N_BITS-1:0]  entrada_a_r;
   logic [N_BITS-1:0]  entrada_b_r;
   logic [OP_BITS-1:0] op_sel_r;
   logic [N_BITS-1:0]  resultado_r;
   logic               valido_r;
`ifdef ALU_FLAGS_EN
   logic               flag_cero_r;
   logic               flag_neg_r;
`endif

   logic [2:0] estado_nxt_s;
   logic       load_a_s;
   logic       load_b_s;
   logic       load_op_s;
   logic       capture_s;
   logic       drop_valid_s;

   // Next-state and register-enable decode; borrar overrides any pending load.
   always_comb begin
      estado_nxt_s = estado_r;
      load_a_s     = 1'b0;
      load_b_s     = 1'b0;
      load_op_s    = 1'b0;
      capture_s    = 1'b0;
      drop_valid_s = 1'b0;
      if (bus.borrar) begin
         estado_nxt_s = ESPERA_A;
      end else begin
         case (estado_r)
            ESPERA_A: begin
               if (bus.cargar) begin
                  load_a_s     = 1'b1;
                  estado_nxt_s = ESPERA_B;
               end else begin
                  estado_nxt_s = ESPERA_A;
               end
            end
            ESPERA_B: begin
               if (bus.cargar) begin
                  load_b_s     = 1'b1;
                  estado_nxt_s = ESPERA_OP;
               end else begin
                  estado_nxt_s = ESPERA_B;
               end
            end
            ESPERA_OP: begin
               if (bus.cargar) begin
                  load_op_s    = 1'b1;
                  estado_nxt_s = CALCULA;
               end else begin
                  estado_nxt_s = ESPERA_OP;
               end
            end
            CALCULA: begin
               capture_s    = 1'b1;
               estado_nxt_s = MUESTRA;
            end
            MUESTRA: begin
               // A new operand set starts directly; the old result stays visible but invalid.
               if (bus.cargar) begin
                  load_a_s     = 1'b1;
                  drop_valid_s = 1'b1;
                  estado_nxt_s = ESPERA_B;
               end else begin
                  estado_nxt_s = MUESTRA;
               end
            end
            default: begin
               drop_valid_s = 1'b1;
               estado_nxt_s = ESPERA_A;
            end
         endcase
      end
   end

   // State and operand registers; operands survive borrar.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_r    <= ESPERA_A;
         entrada_a_r <= {N_BITS{1'b0}};
         entrada_b_r <= {N_BITS{1'b0}};
         op_sel_r    <= {OP_BITS{1'b0}};
      end else begin
         estado_r <= estado_nxt_s;
         if (load_a_s) begin
            entrada_a_r <= bus.dato_in;
         end
         if (load_b_s) begin
            entrada_b_r <= bus.dato_in;
         end
         if (load_op_s) begin
            op_sel_r <= bus.dato_in[OP_BITS-1:0];
         end
      end
   end

   // Result capture and validity; borrar clears the held result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resultado_r <= {N_BITS{1'b0}};
         valido_r    <= 1'b0;
`ifdef ALU_FLAGS_EN
         flag_cero_r <= 1'b0;
         flag_neg_r  <= 1'b0;
`endif
      end else if (bus.borrar) begin
         resultado_r <= {N_BITS{1'b0}};
         valido_r    <= 1'b0;
`ifdef ALU_FLAGS_EN
         flag_cero_r <= 1'b0;
         flag_neg_r  <= 1'b0;
`endif
      end else if (capture_s) begin
         resultado_r <= bus.resultado_alu;
         valido_r    <= 1'b1;
`ifdef ALU_FLAGS_EN
         flag_cero_r <= (bus.resultado_alu == {N_BITS{1'b0}});
         flag_neg_r  <= bus.resultado_alu[N_BITS-1];
`endif
      end else if (drop_valid_s) begin
         valido_r <= 1'b0;
      end
   end

   assign bus.estado    = estado_r;
   assign bus.entrada_a = entrada_a_r;
   assign bus.entrada_b = entrada_b_r;
   assign bus.op_sel    = op_sel_r;
   assign bus.resultado = resultado_r;
   assign bus.valido    = valido_r;
`ifdef ALU_FLAGS_EN
   assign bus.flag_cero = flag_cero_r;
   assign bus.flag_neg  = flag_neg_r;
`endif
endmodule
